// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared encodings for the core's memory and write stages
package core_pkg;

  localparam logic [1:0] WSEL_NONE = 2'd0;
  localparam logic [1:0] WSEL_GPR  = 2'd1;
  localparam logic [1:0] WSEL_FPR  = 2'd2;
  localparam logic [1:0] WSEL_PC   = 2'd3;

  localparam logic [1:0] MEM_NONE  = 2'd0;
  localparam logic [1:0] MEM_LOAD  = 2'd1;
  localparam logic [1:0] MEM_STORE = 2'd2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane extract/extend, store replication/strobes, legality check
module mem_lane_align
  import core_pkg::*;
(
  input  logic [1:0]  mem_kind_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic        illegal_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic        is_mem;
  logic        bad;

  always_comb begin
    lane_b = rdata_i[{addr_lo_i, 3'b000} +: 8];
    lane_h = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    unique case (funct3_i)
      F3_B:    load_data_o = {{24{lane_b[7]}}, lane_b};
      F3_H:    load_data_o = {{16{lane_h[15]}}, lane_h};
      F3_BU:   load_data_o = {24'd0, lane_b};
      F3_HU:   load_data_o = {16'd0, lane_h};
      default: load_data_o = rdata_i;
    endcase
  end

  always_comb begin
    unique case (funct3_i)
      F3_B: begin
        wdata_o = {4{store_data_i[7:0]}};
        wstrb_o = 4'b0001 << addr_lo_i;
      end
      F3_H: begin
        wdata_o = {2{store_data_i[15:0]}};
        wstrb_o = 4'b0011 << addr_lo_i;
      end
      default: begin
        wdata_o = store_data_i;
        wstrb_o = 4'b1111;
      end
    endcase
  end

  // Reserved/none kinds never reach memory, so they can never be illegal.
  always_comb begin
    is_mem = (mem_kind_i == MEM_LOAD) || (mem_kind_i == MEM_STORE);
    unique case (funct3_i)
      F3_B, F3_BU: bad = 1'b0;
      F3_H, F3_HU: bad = addr_lo_i[0];
      F3_W:        bad = (addr_lo_i != 2'b00);
      default:     bad = 1'b1;
    endcase
    if ((mem_kind_i == MEM_STORE) && ((funct3_i == F3_BU) || (funct3_i == F3_HU)))
      bad = 1'b1;
    illegal_o = is_mem && bad;
  end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - memory stage: data-memory handshake and result hand-off to write
module mem_access
  import core_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [1:0]        mem_kind,
  input  logic [2:0]        mem_funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  input  logic [31:0]       exec_result,
  input  logic [1:0]        wselector_in,
  input  logic [4:0]        rd_in,
  output logic              done,
  output logic [1:0]        wselector,
  output logic [31:0]       data,
  output logic [4:0]        rd,
  output logic              misaligned,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_wstrb,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata
);

  state_e            state_q;
  logic [2:0]        funct3_q;
  logic [1:0]        addr_lo_q;
  logic [1:0]        wsel_lat_q;
  logic [4:0]        rd_lat_q;
  logic              done_q;
  logic [1:0]        wselector_q;
  logic [31:0]       data_q;
  logic [4:0]        rd_q;
  logic              misaligned_q;
  logic              req_q;
  logic              we_q;
  logic [ADDR_W-1:0] maddr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;

  logic [2:0]  sel_funct3;
  logic [1:0]  sel_addr_lo;
  logic [31:0] load_data;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_wstrb;
  logic        illegal;
  logic        is_mem;

  // In IDLE the aligner judges the incoming op; afterwards it decodes the latched one.
  always_comb begin
    sel_funct3  = (state_q == ST_IDLE) ? mem_funct3 : funct3_q;
    sel_addr_lo = (state_q == ST_IDLE) ? addr[1:0]  : addr_lo_q;
    is_mem      = (mem_kind == MEM_LOAD) || (mem_kind == MEM_STORE);
  end

  mem_lane_align u_align (
    .mem_kind_i   (mem_kind),
    .funct3_i     (sel_funct3),
    .addr_lo_i    (sel_addr_lo),
    .store_data_i (store_data),
    .rdata_i      (dmem_rdata),
    .load_data_o  (load_data),
    .wdata_o      (lane_wdata),
    .wstrb_o      (lane_wstrb),
    .illegal_o    (illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      funct3_q     <= 3'd0;
      addr_lo_q    <= 2'd0;
      wsel_lat_q   <= WSEL_NONE;
      rd_lat_q     <= 5'd0;
      done_q       <= 1'b0;
      wselector_q  <= WSEL_NONE;
      data_q       <= 32'd0;
      rd_q         <= 5'd0;
      misaligned_q <= 1'b0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      maddr_q      <= '0;
      wdata_q      <= 32'd0;
      wstrb_q      <= 4'd0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (enable) begin
            funct3_q   <= mem_funct3;
            addr_lo_q  <= addr[1:0];
            wsel_lat_q <= wselector_in;
            rd_lat_q   <= rd_in;
            if (!is_mem) begin
              state_q      <= ST_FIN;
              done_q       <= 1'b1;
              misaligned_q <= 1'b0;
              wselector_q  <= wselector_in;
              data_q       <= exec_result;
              rd_q         <= rd_in;
            end else if (illegal) begin
              state_q      <= ST_FIN;
              done_q       <= 1'b1;
              misaligned_q <= 1'b1;
              wselector_q  <= WSEL_NONE;
              data_q       <= 32'd0;
              rd_q         <= rd_in;
            end else begin
              state_q <= ST_REQ;
              req_q   <= 1'b1;
              we_q    <= (mem_kind == MEM_STORE);
              maddr_q <= {addr[ADDR_W-1:2], 2'b00};
              wdata_q <= lane_wdata;
              wstrb_q <= (mem_kind == MEM_STORE) ? lane_wstrb : 4'd0;
            end
          end
        end
        ST_REQ: begin
          if (dmem_ack) begin
            state_q      <= ST_FIN;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            wstrb_q      <= 4'd0;
            done_q       <= 1'b1;
            misaligned_q <= 1'b0;
            rd_q         <= rd_lat_q;
            if (we_q) begin
              wselector_q <= WSEL_NONE;
              data_q      <= 32'd0;
            end else begin
              wselector_q <= wsel_lat_q;
              data_q      <= load_data;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign done       = done_q;
  assign wselector  = wselector_q;
  assign data       = data_q;
  assign rd         = rd_q;
  assign misaligned = misaligned_q;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = maddr_q;
  assign dmem_wdata = wdata_q;
  assign dmem_wstrb = wstrb_q;

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - scoreboard bench for mem_access with a scripted memory responder
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  mem_kind = 2'd0;
  logic [2:0]  mem_funct3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] store_data = 32'd0;
  logic [31:0] exec_result = 32'd0;
  logic [1:0]  wselector_in = 2'd0;
  logic [4:0]  rd_in = 5'd0;
  logic        done;
  logic [1:0]  wselector;
  logic [31:0] data;
  logic [4:0]  rd;
  logic        misaligned;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = 32'd0;

  mem_access #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .enable(enable), .mem_kind(mem_kind), .mem_funct3(mem_funct3),
    .addr(addr), .store_data(store_data), .exec_result(exec_result),
    .wselector_in(wselector_in), .rd_in(rd_in), .done(done), .wselector(wselector),
    .data(data), .rd(rd), .misaligned(misaligned), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic [1:0]  ws;
    logic        mis;
    logic        chk_rd;
    logic [4:0]  rd;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  exp_t exp_q[$];
  req_t req_q[$];
  int   nchecks = 0;
  int   nerr = 0;
  int   cyc = 0;
  int   ack_delay = 0;
  logic [31:0] mem_word = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expected completion.
  initial begin
    forever begin
      @(negedge clk);
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("data", data, e.data);
          chk("wselector", {30'd0, wselector}, {30'd0, e.ws});
          chk("misaligned", {31'd0, misaligned}, {31'd0, e.mis});
          if (e.chk_rd) chk("rd", {27'd0, rd}, {27'd0, e.rd});
        end
      end
    end
  end

  // Memory responder: checks each new request, acks after ack_delay cycles.
  initial begin
    bit mbusy = 1'b0;
    int mcnt = 0;
    forever begin
      @(negedge clk);
      if (dmem_req) begin
        if (!mbusy) begin
          mbusy = 1'b1;
          mcnt = 0;
          if (req_q.size() == 0) begin
            chk("unexpected_req", 32'd1, 32'd0);
          end else begin
            req_t r;
            r = req_q.pop_front();
            chk("dmem_addr", dmem_addr, r.addr);
            chk("dmem_we", {31'd0, dmem_we}, {31'd0, r.we});
            if (r.we) begin
              chk("dmem_wdata", dmem_wdata, r.wdata);
              chk("dmem_wstrb", {28'd0, dmem_wstrb}, {28'd0, r.wstrb});
            end
          end
        end
        if (mcnt == ack_delay) begin
          dmem_ack = 1'b1;
          dmem_rdata = mem_word;
        end else begin
          mcnt++;
        end
      end else begin
        dmem_ack = 1'b0;
        mbusy = 1'b0;
      end
    end
  end

  task automatic issue(input logic [1:0] k, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input logic [31:0] er, input logic [1:0] ws,
                       input logic [4:0] r, input int delay, input logic [31:0] rword,
                       input logic [31:0] xdata, input logic [1:0] xws, input logic xmis,
                       input logic xchk_rd, input logic xreq, input logic [31:0] xaddr,
                       input logic [31:0] xwdata, input logic [3:0] xwstrb);
    exp_t e;
    req_t q;
    @(posedge clk);
    #1;
    mem_kind = k; mem_funct3 = f3; addr = a; store_data = sd; exec_result = er;
    wselector_in = ws; rd_in = r; ack_delay = delay; mem_word = rword;
    enable = 1'b1;
    e.cyc = cyc + (xreq ? delay + 2 : 1);
    e.data = xdata; e.ws = xws; e.mis = xmis; e.chk_rd = xchk_rd; e.rd = r;
    exp_q.push_back(e);
    if (xreq) begin
      q.addr = xaddr; q.we = (k == 2'd2); q.wdata = xwdata; q.wstrb = xwstrb;
      req_q.push_back(q);
    end
    @(posedge clk);
    #1;
    enable = 1'b0;
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
    nchecks++;
    if (exp_q.size() != 0) begin
      nerr++;
      $display("FAIL done_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic op(input logic [1:0] k, input logic [2:0] f3, input logic [31:0] a,
                    input logic [31:0] sd, input logic [31:0] er, input logic [1:0] ws,
                    input logic [4:0] r, input int delay, input logic [31:0] rword,
                    input logic [31:0] xdata, input logic [1:0] xws, input logic xmis,
                    input logic xchk_rd, input logic xreq, input logic [31:0] xaddr,
                    input logic [31:0] xwdata, input logic [3:0] xwstrb);
    issue(k, f3, a, sd, er, ws, r, delay, rword, xdata, xws, xmis, xchk_rd, xreq, xaddr, xwdata, xwstrb);
    wait_done();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_misaligned", {31'd0, misaligned}, 32'd0);
    chk("rst_req_we", {30'd0, dmem_req, dmem_we}, 32'd0);
    chk("rst_wstrb_wsel", {26'd0, dmem_wstrb, wselector}, 32'd0);
    chk("rst_data", data, 32'd0);
    chk("rst_rd", {27'd0, rd}, 32'd0);
    chk("rst_dmem_addr", dmem_addr, 32'd0);
    chk("rst_dmem_wdata", dmem_wdata, 32'd0);

    //  kind  f3      addr         sd            er            ws  rd  dly rword         xdata         xws mis crd req xaddr         xwdata        xwstrb
    op(2'd0, 3'b000, 32'h0000_0000, 32'h0,        32'h1234_5678, 2'd1, 5'd7,  0, 32'h0,        32'h1234_5678, 2'd1, 0, 1, 0, 32'h0,        32'h0,        4'h0);
    op(2'd1, 3'b000, 32'h0000_0103, 32'h0,        32'h0,        2'd1, 5'd3,  2, 32'h80AA_BBCC, 32'hFFFF_FF80, 2'd1, 0, 1, 1, 32'h0000_0100, 32'h0,        4'h0);
    op(2'd1, 3'b101, 32'h0000_0202, 32'h0,        32'h0,        2'd2, 5'd9,  0, 32'hBEEF_1234, 32'h0000_BEEF, 2'd2, 0, 1, 1, 32'h0000_0200, 32'h0,        4'h0);
    op(2'd2, 3'b000, 32'h0000_0012, 32'h0000_00A5, 32'h0,       2'd1, 5'd1,  1, 32'h0,        32'h0,        2'd0, 0, 0, 1, 32'h0000_0010, 32'hA5A5_A5A5, 4'b0100);
    op(2'd1, 3'b010, 32'h0000_0006, 32'h0,        32'h0000_DEAD, 2'd1, 5'd5,  0, 32'h0,        32'h0,        2'd0, 1, 0, 0, 32'h0,        32'h0,        4'h0);
    op(2'd0, 3'b000, 32'h0000_0000, 32'h0,        32'h0000_0042, 2'd3, 5'd31, 0, 32'h0,        32'h0000_0042, 2'd3, 0, 1, 0, 32'h0,        32'h0,        4'h0);
    op(2'd2, 3'b001, 32'h0000_0022, 32'h1234_5678, 32'h0,       2'd1, 5'd2,  1, 32'h0,        32'h0,        2'd0, 0, 0, 1, 32'h0000_0020, 32'h5678_5678, 4'b1100);
    op(2'd1, 3'b001, 32'h0000_0302, 32'h0,        32'h0,        2'd1, 5'd4,  0, 32'h8001_0000, 32'hFFFF_8001, 2'd1, 0, 1, 1, 32'h0000_0300, 32'h0,        4'h0);
    op(2'd1, 3'b000, 32'h0000_0401, 32'h0,        32'h0,        2'd1, 5'd6,  1, 32'h0000_7F00, 32'h0000_007F, 2'd1, 0, 1, 1, 32'h0000_0400, 32'h0,        4'h0);
    op(2'd2, 3'b100, 32'h0000_0000, 32'h0000_0011, 32'h0,       2'd1, 5'd8,  0, 32'h0,        32'h0,        2'd0, 1, 0, 0, 32'h0,        32'h0,        4'h0);
    op(2'd1, 3'b011, 32'h0000_0008, 32'h0,        32'h0,        2'd1, 5'd8,  0, 32'h0,        32'h0,        2'd0, 1, 0, 0, 32'h0,        32'h0,        4'h0);
    op(2'd3, 3'b010, 32'h0000_0003, 32'h0,        32'hABCD_0000, 2'd1, 5'd2,  0, 32'h0,        32'hABCD_0000, 2'd1, 0, 1, 0, 32'h0,        32'h0,        4'h0);
    op(2'd2, 3'b010, 32'h0000_0020, 32'hDEAD_BEEF, 32'h0,       2'd1, 5'd3,  0, 32'h0,        32'h0,        2'd0, 0, 0, 1, 32'h0000_0020, 32'hDEAD_BEEF, 4'b1111);

    // Reset while the memory withholds ack: the access is dropped without a done.
    begin
      req_t q;
      @(posedge clk);
      #1;
      mem_kind = 2'd1; mem_funct3 = 3'b010; addr = 32'h0000_0040; ack_delay = 1000;
      wselector_in = 2'd1; rd_in = 5'd10; enable = 1'b1;
      q.addr = 32'h0000_0040; q.we = 1'b0; q.wdata = 32'h0; q.wstrb = 4'h0;
      req_q.push_back(q);
      @(posedge clk);
      #1 enable = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("req_after_reset", {31'd0, dmem_req}, 32'd0);
      chk("done_after_reset", {31'd0, done}, 32'd0);
      repeat (4) @(posedge clk);
    end

    // A second enable arriving during REQ must be dropped.
    issue(2'd1, 3'b010, 32'h0000_0044, 32'h0, 32'h0, 2'd1, 5'd12, 3, 32'hCAFE_F00D,
          32'hCAFE_F00D, 2'd1, 0, 1, 1, 32'h0000_0044, 32'h0, 4'h0);
    mem_kind = 2'd0; exec_result = 32'h0000_FFFF; enable = 1'b1;
    @(posedge clk);
    #1 enable = 1'b0;
    wait_done();
    repeat (6) @(posedge clk);
    chk("req_queue_drained", req_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
